// File: rtl/tx_jesd204b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tx_jesd204b_pkg
//  Brief    : Shared control characters, state encoding and ILAS constants
//             for the JESD204B transmit link-control stage.
//  Revision : 1.0 - initial release
// ============================================================================
package tx_jesd204b_pkg;

  // 8b/10b control characters used in CGS and ILAS
  localparam logic [7:0] K_R = 8'h1C;  // K28.0 /R/ multiframe start
  localparam logic [7:0] K_A = 8'h7C;  // K28.3 /A/ multiframe end
  localparam logic [7:0] K_Q = 8'h9C;  // K28.4 /Q/ config data follows
  localparam logic [7:0] K_K = 8'hBC;  // K28.5 /K/ code-group sync

  // ILAS is four multiframes long and carries fourteen config octets
  localparam int ILAS_MF = 4;
  localparam int CFG_LEN = 14;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tx_jesd204b_ctrl_cfg_rom.sv
`default_nettype none
// ============================================================================
//  Module   : tx_ilas_cfg_rom
//  Brief    : Constant ILAS link-configuration table (octets 0..13). The
//             checksum octet is folded in at elaboration time.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_ilas_cfg_rom
  import tx_jesd204b_pkg::*;
#(
  parameter logic [7:0] DID = 8'h00,
  parameter logic [3:0] BID = 4'h0,
  parameter logic [4:0] LID = 5'h00,
  parameter int         K   = 32
) (
  input  logic [3:0] idx,
  output logic [7:0] cfg
);

  // Link parameters without the checksum; single lane, F=1, M=1, N=N'=8,
  // subclass 1, JESD204B, S=1, scrambling off.
  function automatic logic [7:0] base_octet(input int i);
    case (i)
      0:       return DID;
      1:       return {4'h0, BID};
      2:       return {3'b000, LID};
      5:       return 8'(K - 1);
      7:       return 8'h07;
      8:       return 8'h27;
      9:       return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  // Checksum: modulo-256 sum of every octet that precedes it
  function automatic logic [7:0] calc_fchk(input int n);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      sum = sum + base_octet(i);
    end
    return sum;
  endfunction

  localparam logic [7:0] FCHK = calc_fchk(CFG_LEN - 1);

  // Table lookup; out-of-range indices read as zero
  always_comb begin
    cfg = 8'h00;
    if (int'(idx) == CFG_LEN - 1) begin
      cfg = FCHK;
    end else if (int'(idx) < CFG_LEN - 1) begin
      cfg = base_octet(int'(idx));
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_jesd204b_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tx_jesd204b_ctrl
//  Brief    : JESD204B transmit link control. Sequences CGS -> ILAS -> DATA
//             towards the 8b/10b link layer, keeps the LMFC, and watches
//             SYNC~ for resynchronisation requests and error reports.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_jesd204b_ctrl
  import tx_jesd204b_pkg::*;
#(
  parameter int         K        = 32,
  parameter logic [7:0] DID      = 8'h00,
  parameter logic [3:0] BID      = 4'h0,
  parameter logic [4:0] LID      = 5'h00,
  parameter int         RESYNC_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_n,
  input  logic [7:0] s_data,
  input  logic       s_vld,
  output logic       s_ready,
  output logic [7:0] o_data,
  output logic       o_k,
  output logic       o_vld,
  output logic [1:0] o_state,
  output logic       o_lmfc,
  output logic       o_sync_err
);

  localparam int CW = $clog2(K);
  localparam int RW = $clog2(RESYNC_N + 1);

  logic          sync_meta;
  logic          sync_s;
  logic [CW-1:0] lmfc_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          cnt_last;
  logic [RW-1:0] run_cnt;
  logic          resync;
  state_t        state;
  state_t        state_nxt;
  logic [1:0]    mf_idx;
  logic [1:0]    mf_nxt;
  logic [3:0]    cfg_idx;
  logic [7:0]    cfg_octet;
  logic [7:0]    ilas_data;
  logic          ilas_k;

  tx_ilas_cfg_rom #(
    .DID (DID),
    .BID (BID),
    .LID (LID),
    .K   (K)
  ) u_cfg_rom (
    .idx (cfg_idx),
    .cfg (cfg_octet)
  );

  assign o_state = state;

  // Two-flop synchroniser; resets low so the link starts out in sync request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= sync_n;
      sync_s    <= sync_meta;
    end
  end

  // Free-running LMFC octet counter, 0..K-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lmfc_cnt <= '0;
    end else begin
      lmfc_cnt <= cnt_nxt;
    end
  end

  // Length of the current sync_s-low run while the link is past CGS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (state == CGS || sync_s || resync) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + RW'(1);
    end
  end

  // Next-state, LMFC advance and resync decision
  always_comb begin
    cnt_last  = (lmfc_cnt == CW'(K - 1));
    cnt_nxt   = cnt_last ? '0 : lmfc_cnt + CW'(1);
    // The current low cycle is the RESYNC_N-th one of the run
    resync    = (state != CGS) && !sync_s && (run_cnt == RW'(RESYNC_N - 1));
    state_nxt = state;
    mf_nxt    = mf_idx;
    case (state)
      CGS: begin
        // Leave on the last octet of a multiframe so ILAS starts on LMFC
        if (sync_s && cnt_last) begin
          state_nxt = ILAS;
          mf_nxt    = 2'd0;
        end
      end
      ILAS: begin
        // Resync has priority over the hand-off to DATA
        if (resync) begin
          state_nxt = CGS;
        end else if (cnt_last) begin
          if (mf_idx == 2'(ILAS_MF - 1)) begin
            state_nxt = DATA;
          end else begin
            mf_nxt = mf_idx + 2'd1;
          end
        end
      end
      DATA: begin
        if (resync) begin
          state_nxt = CGS;
        end
      end
      default: state_nxt = CGS;
    endcase
  end

  // ILAS octet for the position being loaded into the output registers
  always_comb begin
    cfg_idx   = 4'(cnt_nxt - CW'(2));
    ilas_data = 8'(cnt_nxt);
    ilas_k    = 1'b0;
    if (cnt_nxt == '0) begin
      ilas_data = K_R;
      ilas_k    = 1'b1;
    end else if (cnt_nxt == CW'(K - 1)) begin
      ilas_data = K_A;
      ilas_k    = 1'b1;
    end else if (mf_nxt == 2'd1 && cnt_nxt == CW'(1)) begin
      ilas_data = K_Q;
      ilas_k    = 1'b1;
    end else if (mf_nxt == 2'd1 && cnt_nxt >= CW'(2) && cnt_nxt <= CW'(CFG_LEN + 1)) begin
      ilas_data = cfg_octet;
    end
  end

  // State register and registered link-layer outputs, aligned with lmfc_cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CGS;
      mf_idx     <= 2'd0;
      o_data     <= 8'h00;
      o_k        <= 1'b0;
      o_vld      <= 1'b0;
      s_ready    <= 1'b0;
      o_lmfc     <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      mf_idx     <= mf_nxt;
      o_lmfc     <= (cnt_nxt == '0);
      // A short run only counts as an error when it ends inside DATA
      o_sync_err <= (state == DATA) && sync_s && (run_cnt != '0);
      case (state_nxt)
        ILAS: begin
          o_data  <= ilas_data;
          o_k     <= ilas_k;
          o_vld   <= 1'b1;
          s_ready <= 1'b0;
        end
        DATA: begin
          s_ready <= 1'b1;
          o_k     <= 1'b0;
          if (s_vld && s_ready) begin
            o_data <= s_data;
            o_vld  <= 1'b1;
          end else begin
            o_vld  <= 1'b0;
          end
        end
        default: begin
          o_data  <= K_K;
          o_k     <= 1'b1;
          o_vld   <= 1'b1;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_jesd204b_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_jesd204b_ctrl
//  Brief    : Directed self-checking bench for tx_jesd204b_ctrl (K=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_jesd204b_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync_n;
  logic [7:0] s_data;
  logic       s_vld;
  logic       s_ready;
  logic [7:0] o_data;
  logic       o_k;
  logic       o_vld;
  logic [1:0] o_state;
  logic       o_lmfc;
  logic       o_sync_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;  // edges since reset release; LMFC position is cyc % 32

  logic [14:0] obs;
  assign obs = {o_state, o_data, o_k, o_vld, s_ready, o_lmfc, o_sync_err};

  // Hand-computed config octets for DID=0,BID=0,LID=0,K=32;
  // checksum 1F+07+27+20 = 6D
  logic [7:0] cfg_tab [14] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h00,
                               8'h07, 8'h27, 8'h20, 8'h00, 8'h00, 8'h00, 8'h6D};

  tx_jesd204b_ctrl #(
    .K        (32),
    .DID      (8'h00),
    .BID      (4'h0),
    .LID      (5'h00),
    .RESYNC_N (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_n     (sync_n),
    .s_data     (s_data),
    .s_vld      (s_vld),
    .s_ready    (s_ready),
    .o_data     (o_data),
    .o_k        (o_k),
    .o_vld      (o_vld),
    .o_state    (o_state),
    .o_lmfc     (o_lmfc),
    .o_sync_err (o_sync_err)
  );

  always #4 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] ev(input logic [1:0] st, input logic [7:0] d,
                                     input logic k, input logic v, input logic r,
                                     input logic l, input logic e);
    return {st, d, k, v, r, l, e};
  endfunction

  function automatic logic [8:0] ilas_exp(input int mf, input int oc);
    if (oc == 0)                           return {1'b1, 8'h1C};
    if (oc == 31)                          return {1'b1, 8'h7C};
    if (mf == 1 && oc == 1)                return {1'b1, 8'h9C};
    if (mf == 1 && oc >= 2 && oc <= 15)    return {1'b0, cfg_tab[oc-2]};
    return {1'b0, 8'(oc)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] cgs_exp();
    return ev(2'd0, 8'hBC, 1'b1, 1'b1, 1'b0, (cyc % 32 == 0), 1'b0);
  endfunction

  // Expects ILAS octet 0 visible now; walks all 128 octets into DATA
  task automatic check_ilas(input string tag);
    logic [8:0] e;
    for (int j = 0; j < 128; j++) begin
      e = ilas_exp(j / 32, j % 32);
      chk($sformatf("%s_mf%0d_oct%0d", tag, j / 32, j % 32), obs,
          ev(2'd1, e[7:0], e[8], 1'b1, 1'b0, (j % 32 == 0), 1'b0));
      step();
    end
    chk({tag, "_enter_data"}, obs, ev(2'd2, 8'h7C, 1'b0, 1'b0, 1'b1, (cyc % 32 == 0), 1'b0));
  endtask

  initial begin
    rst    = 1'b1;
    sync_n = 1'b0;
    s_data = 8'h00;
    s_vld  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", obs, 15'd0);
    rst = 1'b0;
    cyc = 0;

    // CGS with SYNC~ held low
    for (int i = 0; i < 106; i++) begin
      step();
      chk($sformatf("cgs_%0d", cyc), obs, cgs_exp());
    end

    // SYNC~ released at lmfc_cnt=10; ILAS begins at the next LMFC (edge 128)
    sync_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      step();
      chk($sformatf("cgs_wait_%0d", cyc), obs, cgs_exp());
    end
    step();
    check_ilas("ilas");

    // Data pass-through, one cycle latency
    for (int i = 0; i < 256; i++) begin
      s_data = 8'(i);
      s_vld  = 1'b1;
      step();
      chk($sformatf("data_%0d", i), obs, ev(2'd2, 8'(i), 1'b0, 1'b1, 1'b1, (cyc % 32 == 0), 1'b0));
    end
    s_data = 8'hA5; s_vld = 1'b1; step();
    chk("vld_tog_1", obs, ev(2'd2, 8'hA5, 1'b0, 1'b1, 1'b1, (cyc % 32 == 0), 1'b0));
    s_data = 8'h5A; s_vld = 1'b0; step();
    chk("vld_tog_0_hold", obs, ev(2'd2, 8'hA5, 1'b0, 1'b0, 1'b1, (cyc % 32 == 0), 1'b0));
    s_data = 8'h5A; s_vld = 1'b1; step();
    chk("vld_tog_1b", obs, ev(2'd2, 8'h5A, 1'b0, 1'b1, 1'b1, (cyc % 32 == 0), 1'b0));
    s_data = 8'h33; s_vld = 1'b0; step();
    chk("vld_tog_0b_hold", obs, ev(2'd2, 8'h5A, 1'b0, 1'b0, 1'b1, (cyc % 32 == 0), 1'b0));

    // Three-cycle SYNC~ dip: one error pulse, link stays in DATA
    sync_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("short_dip_%0d", k), obs,
          ev(2'd2, 8'h5A, 1'b0, 1'b0, 1'b1, (cyc % 32 == 0), (k == 6)));
      if (k == 3) sync_n = 1'b1;
    end

    // Four-cycle SYNC~ dip: back to CGS
    sync_n = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 6)
        chk($sformatf("long_dip_%0d", k), obs,
            ev(2'd2, 8'h5A, 1'b0, 1'b0, 1'b1, (cyc % 32 == 0), 1'b0));
      else
        chk("long_dip_cgs", obs, cgs_exp());
      if (k == 4) sync_n = 1'b1;
    end

    // Recovery: realigned ILAS at the next LMFC boundary, then DATA
    do begin
      step();
      if (cyc % 32 != 0) chk($sformatf("recover_cgs_%0d", cyc), obs, cgs_exp());
    end while (cyc % 32 != 0);
    check_ilas("resync_ilas");
    s_data = 8'h3C; s_vld = 1'b1; step();
    chk("resync_data", obs, ev(2'd2, 8'h3C, 1'b0, 1'b1, 1'b1, (cyc % 32 == 0), 1'b0));

    // Drive another ILAS and reset it at MF2 octet 5
    s_vld  = 1'b0;
    sync_n = 1'b0;
    repeat (6) step();
    chk("pre_rst_cgs", obs, cgs_exp());
    sync_n = 1'b1;
    do step(); while (cyc % 32 != 0);
    chk("pre_rst_ilas0", obs, ev(2'd1, 8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (69) step();
    chk("pre_rst_mf2_oct5", obs, ev(2'd1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    chk("async_rst_immediate", obs, 15'd0);
    step();
    chk("rst_held", obs, 15'd0);
    sync_n = 1'b0;
    rst    = 1'b0;
    cyc    = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      chk($sformatf("post_rst_cgs_%0d", cyc), obs, cgs_exp());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
